// File: rtl/run_ctrl.sv
// run_ctrl: program run sequencer -- holds the core in reset, times its run, and
// muxes the data-memory port between the core (RUN) and the host (otherwise).
module run_ctrl #(
   parameter int unsigned RST_CYCLES = 2,
   parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       core_done,
   output logic       core_rst,
   input  logic       core_we,
   input  logic [7:0] core_addr,
   input  logic [7:0] core_di,
   input  logic       host_req,
   input  logic       host_we,
   input  logic [7:0] host_addr,
   input  logic [7:0] host_di,
   output logic       host_gnt,
   output logic       dm_we,
   output logic [7:0] dm_addr,
   output logic [7:0] dm_di,
   output logic       busy,
   output logic       finished,
   output logic       timeout,
   output logic [15:0] cycles
);
   typedef enum logic [2:0] {IDLE, RST, RUN, DONE, TMO} state_t;
   state_t      r_state;
   logic [15:0] r_cycles;
   logic [15:0] r_rcnt;
   logic        w_run;
   logic        w_honour;
   logic        w_limit;
   assign w_run    = r_state == RUN;
   // cycles is 0 only in the first RUN cycle, where core_done is not yet valid
   assign w_honour = w_run && r_cycles != 16'd0 && core_done;
   assign w_limit  = r_cycles == MAX_CYCLES - 16'd1;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cycles <= '0;
         r_rcnt   <= '0;
      end else begin
         case (r_state)
            IDLE, DONE, TMO: if (start) begin
               r_state  <= RST;
               r_cycles <= '0;
               r_rcnt   <= '0;
            end
            RST: begin
               r_rcnt <= r_rcnt + 16'd1;
               if (r_rcnt == 16'(RST_CYCLES - 1)) r_state <= RUN;
            end
            RUN: begin
               if (r_cycles != 16'hFFFF) r_cycles <= r_cycles + 16'd1;
               if (w_honour) r_state <= DONE;
               else if (w_limit) r_state <= TMO;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign core_rst = !w_run;
   assign busy     = r_state == RST || w_run;
   assign finished = r_state == DONE;
   assign timeout  = r_state == TMO;
   assign cycles   = r_cycles;
   assign host_gnt = w_run ? 1'b0 : host_req;
   assign dm_we    = w_run ? core_we : host_req & host_we;
   assign dm_addr  = w_run ? core_addr : host_addr;
   assign dm_di    = w_run ? core_di : host_di;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed bench with a run-phase model checked every cycle plus literal spot checks.
module tb_run_ctrl;
   localparam int RSTC = 2;
   localparam int MAXC = 5;
   logic clk = 0, reset = 1, start = 0, core_done = 0, core_we = 0;
   logic host_req = 0, host_we = 0;
   logic [7:0] core_addr = 0, core_di = 0, host_addr = 0, host_di = 0;
   logic core_rst, host_gnt, dm_we, busy, finished, timeout;
   logic [7:0] dm_addr, dm_di;
   logic [15:0] cycles;
   int n_chk = 0, n_err = 0;

   run_ctrl #(.RST_CYCLES(RSTC), .MAX_CYCLES(16'(MAXC))) dut (
      .clk(clk), .reset(reset), .start(start), .core_done(core_done), .core_rst(core_rst),
      .core_we(core_we), .core_addr(core_addr), .core_di(core_di),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_di(host_di),
      .host_gnt(host_gnt), .dm_we(dm_we), .dm_addr(dm_addr), .dm_di(dm_di),
      .busy(busy), .finished(finished), .timeout(timeout), .cycles(cycles));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: run phase described by remaining reset cycles, a run flag and a run length.
   bit m_valid = 0, m_run = 0, m_fin = 0, m_tmo = 0;
   int m_rst_left = 0, m_runs = 0;
   always @(posedge clk) begin
      if (reset) begin
         m_valid = 1; m_run = 0; m_fin = 0; m_tmo = 0; m_rst_left = 0; m_runs = 0;
      end else if (m_run) begin
         if (m_runs >= 1 && core_done) begin m_run = 0; m_fin = 1; end
         else if (m_runs == MAXC - 1) begin m_run = 0; m_tmo = 1; end
         if (m_runs < 65535) m_runs++;
      end else if (m_rst_left > 0) begin
         m_rst_left--;
         if (m_rst_left == 0) m_run = 1;
      end else if (start) begin
         m_rst_left = RSTC; m_runs = 0; m_fin = 0; m_tmo = 0;
      end
   end

   always @(negedge clk) if (m_valid) begin
      chk("state_flags", {core_rst, busy, finished, timeout},
          {!m_run, m_run || m_rst_left > 0, m_fin, m_tmo});
      chk("cycles", cycles, 64'(m_runs));
      chk("dm_port", {host_gnt, dm_we, dm_addr, dm_di},
          m_run ? {1'b0, core_we, core_addr, core_di}
                : {host_req, host_req & host_we, host_addr, host_di});
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
      #1;
   endtask

   task automatic go;
      start = 1; step(1); start = 0; step(RSTC);
   endtask

   initial begin
      step(2);
      reset = 0;
      mid;
      chk("rst_state", {core_rst, busy, finished, timeout, cycles}, {4'b1000, 16'd0});
      chk("rst_dm_we", dm_we, 0);
      host_req = 1; host_we = 1; host_addr = 8'h10; host_di = 8'hA5;
      mid;
      chk("idle_host", {host_gnt, dm_we, dm_addr, dm_di}, {2'b11, 8'h10, 8'hA5});
      step(1);
      start = 1; step(1); start = 0;
      mid;
      chk("rst1", {core_rst, busy}, 2'b11);
      step(1);
      mid;
      chk("rst2", {core_rst, busy}, 2'b11);
      step(1);
      core_we = 1; core_addr = 8'h20; core_di = 8'h5A; host_addr = 8'h33;
      core_done = 1;
      mid;
      chk("run_core", {core_rst, host_gnt, dm_we, dm_addr, dm_di}, {3'b001, 8'h20, 8'h5A});
      step(2);
      core_done = 0; core_we = 0;
      mid;
      chk("done", {finished, core_rst, cycles}, {2'b11, 16'd2});
      go; step(MAXC);
      mid;
      chk("tmo", {timeout, finished, cycles}, {2'b10, 16'd5});
      go; step(MAXC - 1);
      core_done = 1; step(1); core_done = 0;
      mid;
      chk("done_wins", {finished, timeout, cycles}, {2'b10, 16'd5});
      go; step(2);
      reset = 1; step(1); reset = 0;
      mid;
      chk("mid_run_reset", {core_rst, busy, cycles}, {2'b10, 16'd0});
      reset = 1; start = 1; step(1); reset = 0; start = 0;
      mid;
      chk("reset_wins", busy, 0);
      go;
      start = 1; core_done = 1; host_we = 0; core_we = 1; step(2);
      start = 0; core_done = 0;
      mid;
      chk("start_ign_run", {finished, cycles}, {1'b1, 16'd2});
      start = 1; step(1); start = 0;
      mid;
      chk("restart_clr", {busy, finished, cycles}, {2'b10, 16'd0});
      for (int i = 0; i < 12; i++) begin
         host_req = i[0]; host_we = i[1]; host_addr = 8'(i * 7); host_di = 8'(i * 13);
         core_we = i[2]; core_addr = 8'(i * 3); core_di = 8'(i * 5); core_done = (i == 9);
         step(1);
      end
      mid;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
